// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ bursting producers share one FIFO write port.
// Grants one producer at a time and forwards its beats, stalling on fifo_full.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/last/data   per-producer beat offer (data slice i at [i*DATA_W +: DATA_W])
//   req_ready             beat of producer i accepted when req_valid[i] is also high
//   fifo_write/fifo_data  FIFO write strobe and data
//   fifo_full             FIFO back-pressure
//   grant_id, busy        current grantee (0 when idle) and grant-active flag
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_data,
  input  logic                    fifo_full,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_b
    $error("MAX_BURST must be in 1..15");
  end

  typedef enum logic {
    S_ARB,
    S_BURST
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] rr_q, rr_d;

  logic            arb_hit;
  logic [ID_W-1:0] arb_idx;
  logic            vld_g;
  logic            last_g;
  logic [DATA_W-1:0] data_g;
  logic            xfer;
  logic            cnt_done;
  logic [ID_W-1:0] next_ptr;

  // (base + off) mod N_REQ, with off < N_REQ
  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search starting at rr_q; first hit wins
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!arb_hit && req_valid[wrap_idx(rr_q, k)]) begin
        arb_hit = 1'b1;
        arb_idx = wrap_idx(rr_q, k);
      end
    end
  end

  assign busy     = (state_q == S_BURST);
  assign grant_id = grant_q;

  assign vld_g  = req_valid[grant_q];
  assign last_g = req_last[grant_q];
  assign data_g = req_data[int'(grant_q)*DATA_W +: DATA_W];

  // ready depends only on state and fifo_full, never on req_valid
  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_q] = 1'b1;
  end

  assign xfer       = busy && vld_g && !fifo_full;
  assign fifo_write = xfer;
  assign fifo_data  = busy ? data_g : '0;

  assign cnt_done = (cnt_q + 4'd1) == 4'(MAX_BURST);
  assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ?
                    '0 : grant_q + ID_W'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_ARB: begin
        if (arb_hit) begin
          state_d = S_BURST;
          grant_d = arb_idx;
          cnt_d   = '0;
        end
      end
      S_BURST: begin
        // A bubble releases the grant; fifo_full alone never does
        if (!vld_g || (xfer && (last_g || cnt_done))) begin
          state_d = S_ARB;
          grant_d = '0;
          cnt_d   = '0;
          rr_d    = next_ptr;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_ARB;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ARB;
      grant_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

endmodule
